// File: rtl/srt4_otf_quotient_if.sv
// Handshake bundle between the SRT digit-selection stage, the quotient converter
// and the quotient consumer.
interface srt4_otf_quotient_if #(
  parameter int NDIGITS = 4
);
  localparam int QW = 2 * NDIGITS;

  logic          start;
  logic          digit_valid;
  logic [2:0]    digit;
  logic          digit_ready;
  logic          fin_valid;
  logic          rem_neg;
  logic [QW-1:0] quot;
  logic          quot_valid;
  logic          quot_ready;
  logic          dig_err;

  modport master (
    output start, digit_valid, digit, fin_valid, rem_neg, quot_ready,
    input  digit_ready, quot, quot_valid, dig_err
  );

  modport slave (
    input  start, digit_valid, digit, fin_valid, rem_neg, quot_ready,
    output digit_ready, quot, quot_valid, dig_err
  );
endinterface

// File: rtl/srt4_otf_quotient.sv
// Radix-4 SRT on-the-fly quotient converter: keeps the Q / QM = Q-1 pair so the
// final remainder sign correction is a plain select, no carry-propagate add.
module srt4_otf_quotient #(
  parameter int NDIGITS = 4
) (
  input logic               clk,
  input logic               rst_b,
  srt4_otf_quotient_if.slave bus
);
  localparam int QW = 2 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC      = 2'd1,
    WAIT_FIN = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state_reg;
  logic [QW-1:0] q_reg;
  logic [QW-1:0] qm_reg;
  logic [CW-1:0] cnt_reg;
  logic [QW-1:0] quot_reg;
  logic          quot_valid_reg;
  logic          dig_err_reg;
  logic          digit_ready_reg;

  logic [QW-1:0] q_next;
  logic [QW-1:0] qm_next;
  logic          illegal;

  // Append one radix-4 digit; negative digits borrow from QM, positive ones extend Q.
  always_comb begin
    q_next  = {q_reg[QW-3:0], 2'b00};
    qm_next = {qm_reg[QW-3:0], 2'b11};
    illegal = 1'b0;
    case (bus.digit)
      3'b000: begin
        q_next  = {q_reg[QW-3:0], 2'b00};
        qm_next = {qm_reg[QW-3:0], 2'b11};
      end
      3'b001: begin
        q_next  = {q_reg[QW-3:0], 2'b01};
        qm_next = {q_reg[QW-3:0], 2'b00};
      end
      3'b010: begin
        q_next  = {q_reg[QW-3:0], 2'b10};
        qm_next = {q_reg[QW-3:0], 2'b01};
      end
      3'b101: begin
        q_next  = {qm_reg[QW-3:0], 2'b11};
        qm_next = {qm_reg[QW-3:0], 2'b10};
      end
      3'b110: begin
        q_next  = {qm_reg[QW-3:0], 2'b10};
        qm_next = {qm_reg[QW-3:0], 2'b01};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg       <= IDLE;
      q_reg           <= '0;
      qm_reg          <= '1;
      cnt_reg         <= '0;
      quot_reg        <= '0;
      quot_valid_reg  <= 1'b0;
      dig_err_reg     <= 1'b0;
      digit_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg       <= ACC;
            q_reg           <= '0;
            qm_reg          <= '1;
            cnt_reg         <= '0;
            dig_err_reg     <= 1'b0;
            digit_ready_reg <= 1'b1;
          end
        end
        ACC: begin
          if (bus.digit_valid) begin
            q_reg   <= q_next;
            qm_reg  <= qm_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (illegal) begin
              dig_err_reg <= 1'b1;
            end
            if (cnt_reg == CNT_LAST) begin
              state_reg       <= WAIT_FIN;
              digit_ready_reg <= 1'b0;
            end
          end
        end
        WAIT_FIN: begin
          if (bus.fin_valid) begin
            quot_reg       <= bus.rem_neg ? qm_reg : q_reg;
            quot_valid_reg <= 1'b1;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          if (bus.quot_ready) begin
            quot_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.quot        = quot_reg;
  assign bus.quot_valid  = quot_valid_reg;
  assign bus.dig_err     = dig_err_reg;
  assign bus.digit_ready = digit_ready_reg;
endmodule

// File: tb/tb_srt4_otf_quotient.sv
// Randomised and directed bench for the on-the-fly quotient converter, checked
// against the arithmetic value of the signed-digit quotient.
module tb_srt4_otf_quotient;
  localparam int NDIGITS = 4;
  localparam int QW = 2 * NDIGITS;

  logic clk;
  logic rst_b;
  int   n_vec;
  int   n_err;
  logic [QW-1:0] exp_quot;
  logic          exp_err;

  srt4_otf_quotient_if #(.NDIGITS(NDIGITS)) bus ();

  srt4_otf_quotient #(.NDIGITS(NDIGITS)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Quotient = sum of digit * 4^k, minus one when the remainder came out negative.
  function automatic logic [QW-1:0] model_quot(input logic [3*NDIGITS-1:0] digs,
                                               input logic rn, output logic err);
    int v;
    int dv;
    logic [2:0] d;
    v   = 0;
    err = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      d = digs[3*i +: 3];
      case (d)
        3'b000:  dv = 0;
        3'b001:  dv = 1;
        3'b010:  dv = 2;
        3'b101:  dv = -1;
        3'b110:  dv = -2;
        default: begin dv = 0; err = 1'b1; end
      endcase
      v = v * 4 + dv;
    end
    return QW'(v - int'(rn));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Whenever a result is offered it must be the one the model predicted.
  always @(negedge clk) begin
    if (rst_b && bus.quot_valid) begin
      chk("mon_quot", 32'(bus.quot), 32'(exp_quot));
      chk("mon_dig_err", 32'(bus.dig_err), 32'(exp_err));
    end
  end

  // One full division; digits are listed most significant first (bits [11:9] first).
  task automatic do_div(input logic [3*NDIGITS-1:0] digs, input logic rn,
                        input int gap_max, input int hold);
    logic [QW-1:0] q;
    logic          e;
    logic          err_so_far;
    q = model_quot(digs, rn, e);
    err_so_far = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("acc_digit_ready", 32'(bus.digit_ready), 32'd1);
    chk("start_clears_err", 32'(bus.dig_err), 32'd0);
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      for (int g = $urandom_range(gap_max, 0); g > 0; g--) begin
        bus.digit_valid = 1'b0;
        bus.digit       = 3'($urandom);
        bus.fin_valid   = 1'($urandom);
        bus.start       = 1'($urandom);
        tick();
      end
      bus.start       = 1'b0;
      bus.fin_valid   = 1'b0;
      bus.digit_valid = 1'b1;
      bus.digit       = digs[3*i +: 3];
      if (!(digs[3*i +: 3] inside {3'b000, 3'b001, 3'b010, 3'b101, 3'b110}))
        err_so_far = 1'b1;
      tick();
      bus.digit_valid = 1'b0;
      chk("sticky_dig_err", 32'(bus.dig_err), 32'(err_so_far));
    end
    chk("wait_digit_ready", 32'(bus.digit_ready), 32'd0);
    for (int g = $urandom_range(gap_max, 0); g > 0; g--) begin
      bus.digit_valid = 1'($urandom);
      bus.digit       = 3'($urandom);
      bus.start       = 1'($urandom);
      tick();
      chk("no_early_valid", 32'(bus.quot_valid), 32'd0);
    end
    bus.digit_valid = 1'b0;
    bus.start       = 1'b0;
    exp_quot = q;
    exp_err  = e;
    bus.fin_valid = 1'b1;
    bus.rem_neg   = rn;
    tick();
    bus.fin_valid = 1'b0;
    bus.rem_neg   = 1'($urandom);
    chk("fin_latency", 32'(bus.quot_valid), 32'd1);
    chk("quot", 32'(bus.quot), 32'(q));
    for (int h = 0; h < hold; h++) begin
      bus.quot_ready = 1'b0;
      bus.start      = 1'($urandom);
      tick();
      chk("hold_valid", 32'(bus.quot_valid), 32'd1);
      chk("hold_quot", 32'(bus.quot), 32'(q));
    end
    bus.quot_ready = 1'b1;
    bus.start      = 1'($urandom);
    tick();
    bus.quot_ready = 1'b0;
    bus.start      = 1'b0;
    chk("handshake_drop", 32'(bus.quot_valid), 32'd0);
    chk("quot_kept", 32'(bus.quot), 32'(q));
    tick();
    chk("idle_after_done", 32'(bus.digit_ready), 32'd0);
  endtask

  initial begin
    logic          e;
    logic [3*NDIGITS-1:0] digs;
    logic [2:0]    codes [8];
    n_vec = 0;
    n_err = 0;
    exp_quot = '0;
    exp_err  = 1'b0;
    codes = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b011, 3'b100, 3'b111};
    rst_b = 1'b0;
    bus.start = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit = 3'b000;
    bus.fin_valid = 1'b0;
    bus.rem_neg = 1'b0;
    bus.quot_ready = 1'b0;
    #1;
    chk("rst_quot", 32'(bus.quot), 32'd0);
    chk("rst_quot_valid", 32'(bus.quot_valid), 32'd0);
    chk("rst_dig_err", 32'(bus.dig_err), 32'd0);
    chk("rst_digit_ready", 32'(bus.digit_ready), 32'd0);
    tick();
    tick();
    rst_b = 1'b1;
    tick();

    chk("model_s1", 32'(model_quot(12'b001_010_101_000, 1'b0, e)), 32'h5C);
    chk("model_s2", 32'(model_quot(12'b001_010_101_000, 1'b1, e)), 32'h5B);
    chk("model_s3a", 32'(model_quot(12'b110_110_110_110, 1'b0, e)), 32'h56);
    chk("model_s3b", 32'(model_quot(12'b110_110_110_110, 1'b1, e)), 32'h55);
    chk("model_s4", 32'(model_quot(12'b001_011_001_001, 1'b0, e)), 32'h45);
    chk("model_s4_err", 32'(e), 32'd1);

    do_div(12'b001_010_101_000, 1'b0, 0, 0);
    chk("s1_lit", 32'(bus.quot), 32'h5C);
    do_div(12'b001_010_101_000, 1'b1, 0, 0);
    chk("s2_lit", 32'(bus.quot), 32'h5B);
    do_div(12'b110_110_110_110, 1'b0, 1, 1);
    chk("s3a_lit", 32'(bus.quot), 32'h56);
    do_div(12'b110_110_110_110, 1'b1, 1, 1);
    chk("s3b_lit", 32'(bus.quot), 32'h55);
    do_div(12'b001_011_001_001, 1'b0, 0, 0);
    chk("s4_lit", 32'(bus.quot), 32'h45);
    chk("s4_err_held", 32'(bus.dig_err), 32'd1);
    do_div(12'b001_010_101_000, 1'b0, 2, 5);

    // Asynchronous abort mid-division with non-reset state visible.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.digit_valid = 1'b1;
    bus.digit = 3'b011;
    tick();
    bus.digit = 3'b001;
    tick();
    bus.digit_valid = 1'b0;
    chk("pre_rst_err", 32'(bus.dig_err), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("abort_quot", 32'(bus.quot), 32'd0);
    chk("abort_quot_valid", 32'(bus.quot_valid), 32'd0);
    chk("abort_dig_err", 32'(bus.dig_err), 32'd0);
    chk("abort_digit_ready", 32'(bus.digit_ready), 32'd0);
    tick();
    rst_b = 1'b1;
    tick();
    do_div(12'b001_010_101_000, 1'b0, 0, 0);
    chk("s6_lit", 32'(bus.quot), 32'h5C);

    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NDIGITS; i++) begin
        if ($urandom_range(15, 0) == 0)
          digs[3*i +: 3] = codes[$urandom_range(7, 5)];
        else
          digs[3*i +: 3] = codes[$urandom_range(4, 0)];
      end
      do_div(digs, 1'($urandom), 3, $urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
